// File: rtl/instr_loader_pkg.sv
// Shared constants, types and the range-check helper for the instruction loader.
package instr_loader_pkg;

   localparam int ROM_SIZE    = 512;
   localparam int INSTR_WIDTH = 9;
   localparam int AW          = $clog2(ROM_SIZE) + 1;

   typedef logic [AW-1:0]          iaddr_t;
   typedef logic [INSTR_WIDTH-1:0] instr_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      FLUSH = 3'd2,
      START = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } loader_state_t;

   localparam logic [AW:0] ROM_LIMIT = (AW+1)'(ROM_SIZE);

   // True when an image of len words at base would run past the end of RAM.
   // One extra bit keeps the sum from wrapping; base+len == ROM_SIZE is legal.
   function automatic logic range_overflow(input iaddr_t base, input iaddr_t len);
      logic [AW:0] end_addr;
      end_addr = {1'b0, base} + {1'b0, len};
      return end_addr > ROM_LIMIT;
   endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Host stream, RAM write port, start handshake and status of the instruction loader.
//
// Stream handshake: a word transfers on a rising clock edge where both in_valid and
// in_ready are high. in_ready depends only on loader state, never on in_valid; the
// host may hold in_valid low for any number of cycles and must keep in_data stable
// while in_valid is high and in_ready is low.
interface instr_loader_if;
   import instr_loader_pkg::*;

   logic          load_req;
   iaddr_t        load_base;
   iaddr_t        load_len;
   logic          in_valid;
   instr_t        in_data;
   logic          in_ready;
   logic          wr_en;
   iaddr_t        wr_addr;
   instr_t        wr_data;
   logic          start;
   iaddr_t        start_addr;
   logic          busy;
   logic          done;
   logic          err;
   instr_t        checksum;
   loader_state_t dbg_state;

   // Loader side.
   modport slave (
      input  load_req, load_base, load_len, in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data, start, start_addr,
             busy, done, err, checksum, dbg_state
   );

   // Host / fetch-unit side.
   modport master (
      output load_req, load_base, load_len, in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data, start, start_addr,
             busy, done, err, checksum, dbg_state
   );

endinterface

// File: rtl/instr_loader.sv
// Instruction loader: writes a streamed program image into instruction RAM at a
// requested base, then pulses start so the fetch unit begins at that base.
module instr_loader
   import instr_loader_pkg::*;
(
   input logic            clk,
   input logic            reset,
   instr_loader_if.slave  bus
);

   loader_state_t state_q, state_d;
   iaddr_t        base_q, base_d;
   iaddr_t        remaining_q, remaining_d;
   iaddr_t        addr_q, addr_d;
   instr_t        checksum_q, checksum_d;
   logic          wr_en_q, wr_en_d;
   iaddr_t        wr_addr_q, wr_addr_d;
   instr_t        wr_data_q, wr_data_d;
   logic          req_ok;

   // A new request is only honoured when no load is in progress.
   assign req_ok = bus.load_req &&
                   ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

   // State and datapath registers; reset drops everything, including a pending write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         base_q      <= '0;
         remaining_q <= '0;
         addr_q      <= '0;
         checksum_q  <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         remaining_q <= remaining_d;
         addr_q      <= addr_d;
         checksum_q  <= checksum_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // Next-state and datapath updates: latch request, count words, register the RAM write.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      remaining_d = remaining_q;
      addr_d      = addr_q;
      checksum_d  = checksum_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;

      case (state_q)
         IDLE, DONE, ERR: begin
            if (req_ok) begin
               base_d      = bus.load_base;
               remaining_d = bus.load_len;
               addr_d      = bus.load_base;
               checksum_d  = '0;
               if (range_overflow(bus.load_base, bus.load_len)) begin
                  state_d = ERR;
               end else if (bus.load_len == '0) begin
                  state_d = FLUSH;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (bus.in_valid) begin
               wr_en_d     = 1'b1;
               wr_addr_d   = addr_q;
               wr_data_d   = bus.in_data;
               addr_d      = addr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               checksum_d  = checksum_q ^ bus.in_data;
               if (remaining_q == iaddr_t'(1)) begin
                  state_d = FLUSH;
               end
            end
         end
         // The last registered write lands during FLUSH, so RAM is complete before START.
         FLUSH:   state_d = START;
         START:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready   = (state_q == LOAD);
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.start      = (state_q == START);
   assign bus.start_addr = ((state_q == START) || (state_q == DONE)) ? base_q : '0;
   assign bus.busy       = (state_q == LOAD) || (state_q == FLUSH) || (state_q == START);
   assign bus.done       = (state_q == DONE);
   assign bus.err        = (state_q == ERR);
   assign bus.checksum   = checksum_q;
   assign bus.dbg_state  = state_q;

endmodule
